// File: rtl/tetris_pkg.sv
// Shared board geometry, coordinate widths and line-clear FSM encoding.
// Used by line_clear_ctrl and its testbench.
package tetris_pkg;

   localparam int BOARD_W = 10;
   localparam int BOARD_H = 20;
   localparam int BX_W    = 4;
   localparam int BY_W    = 5;
   localparam int ROW_W   = 6;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_EVAL,
      S_COPY,
      S_FILL,
      S_DONE
   } lcc_state_t;

   typedef logic signed [ROW_W-1:0] row_t;

   // Where to go once the source row pointer has moved up one row.
   function automatic lcc_state_t next_row_state(
      input row_t s,
      input row_t d
   );
      lcc_state_t n;
      if (!s[ROW_W-1])
         n = S_READ;
      else if (!d[ROW_W-1])
         n = S_FILL;
      else
         n = S_DONE;
      return n;
   endfunction

endpackage

// File: rtl/line_clear_ctrl.sv
// Post-lock line clear: scans rows bottom-up, drops full rows,
// compacts the rest downward and zero-fills the top.
module line_clear_ctrl
   import tetris_pkg::*;
#(
   parameter int BOARD_W = 10,
   parameter int BOARD_H = 20
) (
   input  logic            CLOCK_50,
   input  logic            reset,
   input  logic            start,
   input  logic [BX_W-1:0] gl_rx,
   input  logic [BY_W-1:0] gl_ry,
   input  logic            gl_we,
   input  logic [BX_W-1:0] gl_wx,
   input  logic [BY_W-1:0] gl_wy,
   input  logic            gl_wdata,
   input  logic            board_rdata,
   output logic [BX_W-1:0] board_rx,
   output logic [BY_W-1:0] board_ry,
   output logic            board_we,
   output logic [BX_W-1:0] board_wx,
   output logic [BY_W-1:0] board_wy,
   output logic            board_wdata,
   output logic            busy,
   output logic            done,
   output logic [4:0]      lines_cleared
);

   localparam logic [BX_W-1:0] X_LAST = BX_W'(BOARD_W - 1);
   localparam logic [BX_W-1:0] X_END  = BX_W'(BOARD_W);
   localparam row_t            ROW_BOT = ROW_W'(BOARD_H - 1);
   localparam row_t            ONE     = 6'sd1;

   lcc_state_t         state;
   row_t               src;
   row_t               dst;
   logic [BX_W-1:0]    x;
   logic [BOARD_W-1:0] rowbuf;
   logic [4:0]         cnt;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state  <= S_IDLE;
         src    <= '0;
         dst    <= '0;
         x      <= '0;
         rowbuf <= '0;
         cnt    <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  src   <= ROW_BOT;
                  dst   <= ROW_BOT;
                  cnt   <= '0;
                  x     <= '0;
                  state <= S_READ;
               end
            end
            S_READ: begin
               // RAM data trails the address by one cycle
               if (x != '0)
                  rowbuf[BX_W'(x - 4'd1)] <= board_rdata;
               if (x == X_END) begin
                  x     <= '0;
                  state <= S_EVAL;
               end else begin
                  x <= x + 4'd1;
               end
            end
            S_EVAL: begin
               if (&rowbuf) begin
                  cnt   <= cnt + 5'd1;
                  src   <= src - ONE;
                  state <= next_row_state(src - ONE, dst);
               end else if (src != dst) begin
                  state <= S_COPY;
               end else begin
                  src   <= src - ONE;
                  dst   <= dst - ONE;
                  state <= next_row_state(src - ONE, dst - ONE);
               end
            end
            S_COPY: begin
               if (x == X_LAST) begin
                  x     <= '0;
                  src   <= src - ONE;
                  dst   <= dst - ONE;
                  state <= next_row_state(src - ONE, dst - ONE);
               end else begin
                  x <= x + 4'd1;
               end
            end
            S_FILL: begin
               if (x == X_LAST) begin
                  x <= '0;
                  if (dst == '0)
                     state <= S_DONE;
                  else
                     dst <= dst - ONE;
               end else begin
                  x <= x + 4'd1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      board_rx    = gl_rx;
      board_ry    = gl_ry;
      board_we    = gl_we;
      board_wx    = gl_wx;
      board_wy    = gl_wy;
      board_wdata = gl_wdata;
      if (state != S_IDLE) begin
         board_rx    = '0;
         board_ry    = src[BY_W-1:0];
         board_we    = 1'b0;
         board_wx    = x;
         board_wy    = dst[BY_W-1:0];
         board_wdata = 1'b0;
      end
      unique case (state)
         S_READ: begin
            if (x < X_END)
               board_rx = x;
         end
         S_COPY: begin
            board_we    = 1'b1;
            board_wdata = rowbuf[x];
         end
         S_FILL: begin
            board_we = 1'b1;
         end
         default: ;
      endcase
   end

   assign busy          = (state != S_IDLE);
   assign done          = (state == S_DONE);
   assign lines_cleared = cnt;

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Directed bench for line_clear_ctrl with a registered-read board RAM
// and a scoreboard of expected completion time and cleared count.
module tb_line_clear_ctrl;
   import tetris_pkg::*;

   logic            CLOCK_50 = 1'b0;
   logic            reset = 1'b1;
   logic            start = 1'b0;
   logic [BX_W-1:0] gl_rx = '0;
   logic [BY_W-1:0] gl_ry = '0;
   logic            gl_we = 1'b0;
   logic [BX_W-1:0] gl_wx = '0;
   logic [BY_W-1:0] gl_wy = '0;
   logic            gl_wdata = 1'b0;
   logic            board_rdata = 1'b0;
   logic [BX_W-1:0] board_rx;
   logic [BY_W-1:0] board_ry;
   logic            board_we;
   logic [BX_W-1:0] board_wx;
   logic [BY_W-1:0] board_wy;
   logic            board_wdata;
   logic            busy;
   logic            done;
   logic [4:0]      lines_cleared;

   always #10 CLOCK_50 = ~CLOCK_50;

   line_clear_ctrl #(
      .BOARD_W(BOARD_W),
      .BOARD_H(BOARD_H)
   ) dut (
      .CLOCK_50     (CLOCK_50),
      .reset        (reset),
      .start        (start),
      .gl_rx        (gl_rx),
      .gl_ry        (gl_ry),
      .gl_we        (gl_we),
      .gl_wx        (gl_wx),
      .gl_wy        (gl_wy),
      .gl_wdata     (gl_wdata),
      .board_rdata  (board_rdata),
      .board_rx     (board_rx),
      .board_ry     (board_ry),
      .board_we     (board_we),
      .board_wx     (board_wx),
      .board_wy     (board_wy),
      .board_wdata  (board_wdata),
      .busy         (busy),
      .done         (done),
      .lines_cleared(lines_cleared)
   );

   logic [BOARD_W-1:0] mem [BOARD_H];

   always @(posedge CLOCK_50) begin
      if (board_we && board_wy < 5'(BOARD_H) && board_wx < 4'(BOARD_W))
         mem[board_wy][board_wx] <= board_wdata;
      if (board_ry < 5'(BOARD_H) && board_rx < 4'(BOARD_W))
         board_rdata <= mem[board_ry][board_rx];
      else
         board_rdata <= 1'b0;
   end

   typedef struct {
      string tag;
      int    done_k;
      int    lines;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   logic [BOARD_W-1:0] img  [BOARD_H];
   logic [BOARD_W-1:0] expb [BOARD_H];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: keep non-full rows in bottom-up order, zeros above them.
   task automatic model(output int lines);
      int w;
      w = BOARD_H - 1;
      lines = 0;
      for (int y = 0; y < BOARD_H; y++) expb[y] = '0;
      for (int y = BOARD_H - 1; y >= 0; y--) begin
         if (&img[y]) lines++;
         else begin
            expb[w] = img[y];
            w--;
         end
      end
   endtask

   task automatic clear_img();
      for (int y = 0; y < BOARD_H; y++) img[y] = '0;
   endtask

   task automatic load_board();
      for (int y = 0; y < BOARD_H; y++) begin
         for (int x = 0; x < BOARD_W; x++) begin
            @(negedge CLOCK_50);
            gl_we    = 1'b1;
            gl_wx    = 4'(x);
            gl_wy    = 5'(y);
            gl_wdata = img[y][x];
         end
      end
      @(negedge CLOCK_50);
      gl_we    = 1'b0;
      gl_wdata = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge CLOCK_50);
      start = 1'b1;
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      start = 1'b0;
   endtask

   task automatic run_case(input string tag, input int start2_at,
                           input bit chk_nowe);
      exp_t e;
      int   lines;
      int   k;
      int   got;
      bit   we_seen;
      model(lines);
      e.tag    = tag;
      e.lines  = lines;
      e.done_k = (lines == 0) ? 241 : 441;
      sb.push_back(e);
      load_board();
      pulse_start();
      k = 1;
      check({tag, " busy_rise"}, 32'(busy), 32'd1);
      got = -1;
      we_seen = 1'b0;
      while (k <= 600) begin
         if (board_we) we_seen = 1'b1;
         if (done) begin
            got = k;
            break;
         end
         start = (k == start2_at);
         @(negedge CLOCK_50);
         k++;
      end
      start = 1'b0;
      e = sb.pop_front();
      check({e.tag, " done_at"}, 32'(got), 32'(e.done_k));
      check({e.tag, " lines"}, 32'(lines_cleared), 32'(e.lines));
      if (chk_nowe) check({tag, " no_we"}, 32'(we_seen), 32'd0);
      @(negedge CLOCK_50);
      check({tag, " busy_fall"}, 32'(busy), 32'd0);
      for (int y = 0; y < BOARD_H; y++)
         check($sformatf("%s row%0d", tag, y), 32'(mem[y]), 32'(expb[y]));
   endtask

   initial begin
      int k;
      // reset and idle pass-through
      repeat (2) @(negedge CLOCK_50);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst lines", 32'(lines_cleared), 32'd0);
      reset = 1'b0;
      @(negedge CLOCK_50);
      gl_we    = 1'b1;
      gl_wx    = 4'd3;
      gl_wy    = 5'd7;
      gl_wdata = 1'b1;
      gl_rx    = 4'd5;
      gl_ry    = 5'd2;
      #1;
      check("pt we", 32'(board_we), 32'd1);
      check("pt wx", 32'(board_wx), 32'd3);
      check("pt wy", 32'(board_wy), 32'd7);
      check("pt wdata", 32'(board_wdata), 32'd1);
      check("pt rx", 32'(board_rx), 32'd5);
      check("pt ry", 32'(board_ry), 32'd2);
      @(negedge CLOCK_50);
      gl_we    = 1'b0;
      gl_wdata = 1'b0;
      gl_rx    = '0;
      gl_ry    = '0;

      // empty board
      clear_img();
      run_case("empty", 0, 1'b1);

      // one full row, single cell above it
      clear_img();
      img[19] = 10'h3FF;
      img[18] = 10'h008;
      run_case("one", 0, 1'b0);

      // tetris: bottom four rows full
      clear_img();
      for (int y = 16; y < 20; y++) img[y] = 10'h3FF;
      run_case("four", 0, 1'b0);

      // split clear with a patterned row between
      clear_img();
      img[19] = 10'h3FF;
      img[18] = 10'h155;
      img[17] = 10'h3FF;
      run_case("split", 0, 1'b0);

      // a second start while busy is ignored
      clear_img();
      img[19] = 10'h3FF;
      img[18] = 10'h008;
      run_case("restart", 50, 1'b0);

      // reset in the middle of a COPY
      load_board();
      pulse_start();
      k = 1;
      while (k < 28) begin
         @(negedge CLOCK_50);
         k++;
      end
      check("copy we", 32'(board_we), 32'd1);
      reset    = 1'b1;
      gl_we    = 1'b1;
      gl_wx    = '0;
      gl_wy    = '0;
      gl_wdata = 1'b0;
      @(negedge CLOCK_50);
      check("mid rst busy", 32'(busy), 32'd0);
      check("mid rst done", 32'(done), 32'd0);
      check("mid rst we", 32'(board_we), 32'd1);
      check("mid rst lines", 32'(lines_cleared), 32'd0);
      gl_we = 1'b0;
      #1;
      check("mid rst we low", 32'(board_we), 32'd0);
      reset = 1'b0;
      @(negedge CLOCK_50);
      check("post rst busy", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
